cfar_target_packer: RTL

Downstream consumer of the CFAR detection stage. Collects one frame of 32-bit CFAR target words (valid/data/last/num stream, no backpressure) into an internal FIFO. At end of frame it emits a framed AXI4-Stream packet (two-word header, target words, optional checksum trailer) toward the PS DMA, honouring `tready` backpressure. Detections arriving while a packet is still draining are dropped and counted.

---
 rtl/cfar_pkg.sv | 45 ++++
 rtl/cfar_pack_fifo.sv | 62 ++++++
 rtl/cfar_target_packer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cfar_pkg.sv
// Shared FSM encoding, header field layout and default constants for the CFAR target packer.
// CFAR_PACK_CHECKSUM_EN adds the TRAIL state carrying the packet XOR.
package cfar_pkg;

    localparam int          FIFO_DEPTH_LOG2_DEF = 9;
    localparam logic [15:0] MAGIC_DEF           = 16'hCFA5;

    localparam int HDR0_MAGIC_LSB = 16;
    localparam int HDR1_OVF_BIT   = 31;
    localparam int HDR1_MIS_BIT   = 30;
    localparam int HDR1_DROP_LSB  = 24;
    localparam int HDR1_DROP_W    = 6;
    localparam int HDR1_CNT_W     = 16;

    localparam logic [HDR1_DROP_W-1:0] DROP_MAX = '1;

`ifdef CFAR_PACK_CHECKSUM_EN
    typedef enum logic [2:0] {ST_COLLECT, ST_HDR0, ST_HDR1, ST_BODY, ST_TRAIL} state_t;
`else
    typedef enum logic [1:0] {ST_COLLECT, ST_HDR0, ST_HDR1, ST_BODY} state_t;
`endif

    function automatic logic [31:0] hdr0_word(input logic [15:0] magic,
                                              input logic [15:0] frame);
        logic [31:0] w;
        w = '0;
        w[HDR0_MAGIC_LSB +: 16] = magic;
        w[15:0]                 = frame;
        return w;
    endfunction

    function automatic logic [31:0] hdr1_word(input logic                   ovf,
                                              input logic                   mis,
                                              input logic [HDR1_DROP_W-1:0] drop,
                                              input logic [HDR1_CNT_W-1:0]  cnt);
        logic [31:0] w;
        w = '0;
        w[HDR1_OVF_BIT]                 = ovf;
        w[HDR1_MIS_BIT]                 = mis;
        w[HDR1_DROP_LSB +: HDR1_DROP_W] = drop;
        w[HDR1_CNT_W-1:0]               = cnt;
        return w;
    endfunction

endpackage

// File: rtl/cfar_pack_fifo.sv
// First-word-fall-through FIFO: RAM array with a prefetched head register, so rd_data is valid
// whenever a word is present; writes while full are discarded, reads when empty are ignored.
module cfar_pack_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   mem_cnt;
    logic                  head_vld;
    logic [WIDTH-1:0]      head_dat;
    logic                  wr_ok, pop, fetch;

    assign wr_ok = wr_en && !full;
    assign pop   = rd_en && head_vld;
    // Refill the head whenever it is empty or being consumed, so back-to-back reads never bubble.
    assign fetch = (mem_cnt != '0) && (!head_vld || pop);

    assign count   = mem_cnt + {{DEPTH_LOG2{1'b0}}, head_vld};
    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign rd_data = head_dat;

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
        if (fetch) head_dat <= mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            head_vld <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (fetch) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, fetch})
                2'b10:   mem_cnt <= mem_cnt + 1'b1;
                2'b01:   mem_cnt <= mem_cnt - 1'b1;
                default: ;
            endcase
            if (fetch)    head_vld <= 1'b1;
            else if (pop) head_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/cfar_target_packer.sv
// Packs one CFAR frame into an AXI4-Stream packet (HDR0, HDR1, body, TRAIL if CFAR_PACK_CHECKSUM_EN);
// header one cycle after the last beat, stalls hold the output stable, input beats outside COLLECT are dropped.
module cfar_target_packer
    import cfar_pkg::*;
#(
    parameter int          FIFO_DEPTH_LOG2 = FIFO_DEPTH_LOG2_DEF,
    parameter logic [15:0] MAGIC           = MAGIC_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfar_data_valid,
    input  logic [31:0] cfar_data,
    input  logic        cfar_data_last,
    input  logic [15:0] cfar_data_num,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        pack_busy
);

`ifdef CFAR_PACK_CHECKSUM_EN
    localparam state_t ST_AFTER_BODY = ST_TRAIL;
`else
    localparam state_t ST_AFTER_BODY = ST_COLLECT;
`endif

    state_t                   state, state_nxt;
    logic [15:0]              cnt, rx_cnt, num_latched, frame_cnt;
    logic                     ovf, mis;
    logic [HDR1_DROP_W-1:0]   drop_cnt, drop_rep, drop_base, drop_nxt;
    logic [FIFO_DEPTH_LOG2:0] fifo_count;
    logic [31:0]              fifo_head;
    logic                     fifo_full, fifo_empty, fifo_wr, fifo_rd;
    logic                     in_collect, wr_beat, last_beat, drop_beat, hs, body_last, pkt_done;

    assign in_collect = (state == ST_COLLECT);
    assign wr_beat    = in_collect && cfar_data_valid;
    assign last_beat  = wr_beat && cfar_data_last;
    assign drop_beat  = !in_collect && cfar_data_valid && cfar_data_last;
    assign hs         = m_axis_tvalid && m_axis_tready;
    assign fifo_wr    = wr_beat && !fifo_full;
    assign fifo_rd    = hs && (state == ST_BODY) && !fifo_empty;
    assign body_last  = (fifo_count == {{FIFO_DEPTH_LOG2{1'b0}}, 1'b1});
    assign pack_busy  = !in_collect;

    // Mismatch is judged against every beat received; overflow losses are reported separately.
    assign mis = (num_latched != rx_cnt);

`ifdef CFAR_PACK_CHECKSUM_EN
    logic [31:0] csum;
    assign pkt_done = hs && (state == ST_TRAIL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      csum <= '0;
        else if (pkt_done) csum <= '0;
        else if (hs)       csum <= csum ^ m_axis_tdata;
    end
`else
    assign pkt_done = hs && (((state == ST_HDR1) && (cnt == '0)) ||
                             ((state == ST_BODY) && body_last));
`endif

    cfar_pack_fifo #(
        .WIDTH      (32),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (fifo_wr),
        .wr_data (cfar_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_COLLECT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_COLLECT: if (last_beat) state_nxt = ST_HDR0;
            ST_HDR0:    if (hs) state_nxt = ST_HDR1;
            ST_HDR1:    if (hs) state_nxt = (cnt == '0) ? ST_AFTER_BODY : ST_BODY;
            ST_BODY:    if (hs && body_last) state_nxt = ST_AFTER_BODY;
`ifdef CFAR_PACK_CHECKSUM_EN
            ST_TRAIL:   if (hs) state_nxt = ST_COLLECT;
`endif
            default:    state_nxt = ST_COLLECT;
        endcase
    end

    // Outputs decode from registered state and the FIFO head, so they cannot move during a stall.
    always_comb begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        case (state)
            ST_HDR0: m_axis_tdata = hdr0_word(MAGIC, frame_cnt);
            ST_HDR1: begin
                m_axis_tdata = hdr1_word(ovf, mis, drop_rep, cnt);
`ifndef CFAR_PACK_CHECKSUM_EN
                m_axis_tlast = (cnt == '0);
`endif
            end
            ST_BODY: begin
                m_axis_tdata = fifo_head;
`ifndef CFAR_PACK_CHECKSUM_EN
                m_axis_tlast = body_last;
`endif
            end
`ifdef CFAR_PACK_CHECKSUM_EN
            ST_TRAIL: begin
                m_axis_tdata = csum;
                m_axis_tlast = 1'b1;
            end
`endif
            default: m_axis_tvalid = 1'b0;
        endcase
    end

    // Drops counted after a frame's header snapshot carry over into the next packet.
    always_comb begin
        drop_base = pkt_done ? (drop_cnt - drop_rep) : drop_cnt;
        drop_nxt  = drop_base;
        if (drop_beat && (drop_base != DROP_MAX)) drop_nxt = drop_base + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            rx_cnt      <= '0;
            num_latched <= '0;
            frame_cnt   <= '0;
            ovf         <= 1'b0;
            drop_cnt    <= '0;
            drop_rep    <= '0;
        end else begin
            drop_cnt <= drop_nxt;
            if (pkt_done) begin
                cnt         <= '0;
                rx_cnt      <= '0;
                num_latched <= '0;
                ovf         <= 1'b0;
                frame_cnt   <= frame_cnt + 16'd1;
            end else if (wr_beat) begin
                rx_cnt <= rx_cnt + 16'd1;
                if (fifo_full) ovf <= 1'b1;
                else           cnt <= cnt + 16'd1;
                if (cfar_data_last) begin
                    num_latched <= cfar_data_num;
                    drop_rep    <= drop_cnt;
                end
            end
        end
    end

endmodule
